// File: rtl/mem_rr_read_mux.sv
// Round-robin arbiter: NUM_CH read channels share one synchronous single-port memory. Grant is issued one edge after the request; tagged data returns one edge after that.
// Full throughput, no stall. Optional macro MEM_MUX_FIXED_PRIO_EN selects lowest-index-wins priority instead of round-robin.
module mem_rr_read_mux #(
  parameter int DATA_W = 4,
  parameter int ADDR_W = 4,
  parameter int NUM_CH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_CH-1:0]        req,
  input  logic [NUM_CH*ADDR_W-1:0] addr_in,
  output logic [NUM_CH-1:0]        grant,
  output logic                     mem_en,
  output logic [ADDR_W-1:0]        mem_addr,
  input  logic [DATA_W-1:0]        mem_rdata,
  output logic [DATA_W-1:0]        rdata_out,
  output logic [NUM_CH-1:0]        rvalid
);

  localparam int IDX_W = $clog2(NUM_CH);
  localparam logic [IDX_W:0]   NUM_CH_W = NUM_CH[IDX_W:0];
  localparam logic [IDX_W-1:0] LAST_CH  = IDX_W'(NUM_CH - 1);

  logic [IDX_W-1:0]  ptr_q, ptr_d;
  logic [NUM_CH-1:0] grant_q, grant_d;
  logic              mem_en_q, mem_en_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic [NUM_CH-1:0] rvalid_q, rvalid_d;

  logic              win_vld;
  logic [IDX_W-1:0]  win_idx;
  logic [IDX_W:0]    cand;

  // Circular search starting at ptr; cand stays one bit wider so the wrap compare is exact.
  always_comb begin
    win_vld = 1'b0;
    win_idx = '0;
    cand    = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      cand = {1'b0, ptr_q} + (IDX_W + 1)'(i);
      if (cand >= NUM_CH_W) begin
        cand = cand - NUM_CH_W;
      end
      if (!win_vld && req[cand[IDX_W-1:0]]) begin
        win_vld = 1'b1;
        win_idx = cand[IDX_W-1:0];
      end
    end
  end

  always_comb begin
    grant_d    = '0;
    mem_en_d   = 1'b0;
    mem_addr_d = mem_addr_q;
    ptr_d      = ptr_q;
    if (win_vld) begin
      grant_d[win_idx] = 1'b1;
      mem_en_d         = 1'b1;
      mem_addr_d       = addr_in[int'(win_idx)*ADDR_W +: ADDR_W];
`ifdef MEM_MUX_FIXED_PRIO_EN
      ptr_d            = '0;
`else
      ptr_d            = (win_idx == LAST_CH) ? '0 : win_idx + 1'b1;
`endif
    end
  end

  // Return stage: the grant issued last edge owns whatever the memory presents now.
  always_comb begin
    rvalid_d = grant_q;
    rdata_d  = (|grant_q) ? mem_rdata : '0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q      <= '0;
      grant_q    <= '0;
      mem_en_q   <= 1'b0;
      mem_addr_q <= '0;
      rdata_q    <= '0;
      rvalid_q   <= '0;
    end else begin
      ptr_q      <= ptr_d;
      grant_q    <= grant_d;
      mem_en_q   <= mem_en_d;
      mem_addr_q <= mem_addr_d;
      rdata_q    <= rdata_d;
      rvalid_q   <= rvalid_d;
    end
  end

  assign grant     = grant_q;
  assign mem_en    = mem_en_q;
  assign mem_addr  = mem_addr_q;
  assign rdata_out = rdata_q;
  assign rvalid    = rvalid_q;

endmodule

// File: tb/tb_mem_rr_read_mux.sv
// Table-driven bench for mem_rr_read_mux; memory modelled combinationally as data = ~address.
// Expected values hand-computed with channel addresses ch0=3, ch1=7, ch2=A, ch3=E.
module tb_mem_rr_read_mux;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  req;
  logic [15:0] addr_in;
  logic [3:0]  grant;
  logic        mem_en;
  logic [3:0]  mem_addr;
  logic [3:0]  mem_rdata;
  logic [3:0]  rdata_out;
  logic [3:0]  rvalid;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  assign mem_rdata = ~mem_addr;

  mem_rr_read_mux #(.DATA_W(4), .ADDR_W(4), .NUM_CH(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .addr_in   (addr_in),
    .grant     (grant),
    .mem_en    (mem_en),
    .mem_addr  (mem_addr),
    .mem_rdata (mem_rdata),
    .rdata_out (rdata_out),
    .rvalid    (rvalid)
  );

  typedef struct {
    logic       rst;
    logic [3:0] req;
    logic [3:0] grant;
    logic       mem_en;
    logic [3:0] mem_addr;
    logic [3:0] rvalid;
    logic [3:0] rdata;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // At most one bit of grant and of rvalid may ever be set.
  always @(negedge clk) begin
    if (!$onehot0(grant) || !$onehot0(rvalid)) begin
      errors++;
      $display("FAIL onehot: grant=%b rvalid=%b at %0t", grant, rvalid, $time);
    end
  end

  initial begin
    int g_cnt [4];
    logic [3:0] prev_g;

    rst     = 1'b1;
    req     = 4'b0;
    addr_in = 16'hEA73;

    //                 rst   req      grant    en    addr   rvalid   rdata
`ifdef MEM_MUX_FIXED_PRIO_EN
    vecs.push_back('{1'b1, 4'b1111, 4'b0000, 1'b0, 4'h0, 4'b0000, 4'h0});
    vecs.push_back('{1'b1, 4'b1111, 4'b0000, 1'b0, 4'h0, 4'b0000, 4'h0});
    vecs.push_back('{1'b0, 4'b1111, 4'b0001, 1'b1, 4'h3, 4'b0000, 4'h0});
    vecs.push_back('{1'b0, 4'b1111, 4'b0001, 1'b1, 4'h3, 4'b0001, 4'hC});
    vecs.push_back('{1'b0, 4'b1111, 4'b0001, 1'b1, 4'h3, 4'b0001, 4'hC});
    vecs.push_back('{1'b0, 4'b1111, 4'b0001, 1'b1, 4'h3, 4'b0001, 4'hC});
    vecs.push_back('{1'b0, 4'b1010, 4'b0010, 1'b1, 4'h7, 4'b0001, 4'hC});
    vecs.push_back('{1'b0, 4'b1100, 4'b0100, 1'b1, 4'hA, 4'b0010, 4'h8});
    vecs.push_back('{1'b0, 4'b0000, 4'b0000, 1'b0, 4'hA, 4'b0100, 4'h5});
    vecs.push_back('{1'b0, 4'b0010, 4'b0010, 1'b1, 4'h7, 4'b0000, 4'h0});
    vecs.push_back('{1'b1, 4'b0000, 4'b0000, 1'b0, 4'h0, 4'b0000, 4'h0});
    vecs.push_back('{1'b0, 4'b1000, 4'b1000, 1'b1, 4'hE, 4'b0000, 4'h0});
    vecs.push_back('{1'b0, 4'b0000, 4'b0000, 1'b0, 4'hE, 4'b1000, 4'h1});
`else
    vecs.push_back('{1'b1, 4'b1111, 4'b0000, 1'b0, 4'h0, 4'b0000, 4'h0});
    vecs.push_back('{1'b1, 4'b1111, 4'b0000, 1'b0, 4'h0, 4'b0000, 4'h0});
    vecs.push_back('{1'b0, 4'b1111, 4'b0001, 1'b1, 4'h3, 4'b0000, 4'h0});
    vecs.push_back('{1'b0, 4'b1111, 4'b0010, 1'b1, 4'h7, 4'b0001, 4'hC});
    vecs.push_back('{1'b0, 4'b1111, 4'b0100, 1'b1, 4'hA, 4'b0010, 4'h8});
    vecs.push_back('{1'b0, 4'b1111, 4'b1000, 1'b1, 4'hE, 4'b0100, 4'h5});
    vecs.push_back('{1'b0, 4'b1111, 4'b0001, 1'b1, 4'h3, 4'b1000, 4'h1});
    vecs.push_back('{1'b0, 4'b1001, 4'b1000, 1'b1, 4'hE, 4'b0001, 4'hC});
    vecs.push_back('{1'b0, 4'b1001, 4'b0001, 1'b1, 4'h3, 4'b1000, 4'h1});
    vecs.push_back('{1'b0, 4'b0000, 4'b0000, 1'b0, 4'h3, 4'b0001, 4'hC});
    vecs.push_back('{1'b0, 4'b1001, 4'b1000, 1'b1, 4'hE, 4'b0000, 4'h0});
    vecs.push_back('{1'b0, 4'b0100, 4'b0100, 1'b1, 4'hA, 4'b1000, 4'h1});
    vecs.push_back('{1'b0, 4'b0000, 4'b0000, 1'b0, 4'hA, 4'b0100, 4'h5});
    vecs.push_back('{1'b0, 4'b0010, 4'b0010, 1'b1, 4'h7, 4'b0000, 4'h0});
    vecs.push_back('{1'b1, 4'b0000, 4'b0000, 1'b0, 4'h0, 4'b0000, 4'h0});
    vecs.push_back('{1'b0, 4'b0110, 4'b0010, 1'b1, 4'h7, 4'b0000, 4'h0});
    vecs.push_back('{1'b0, 4'b0000, 4'b0000, 1'b0, 4'h7, 4'b0010, 4'h8});
    vecs.push_back('{1'b0, 4'b0100, 4'b0100, 1'b1, 4'hA, 4'b0000, 4'h0});
    vecs.push_back('{1'b0, 4'b0100, 4'b0100, 1'b1, 4'hA, 4'b0100, 4'h5});
    vecs.push_back('{1'b0, 4'b0000, 4'b0000, 1'b0, 4'hA, 4'b0100, 4'h5});
`endif

    @(negedge clk);
    for (int v = 0; v < vecs.size(); v++) begin
      rst = vecs[v].rst;
      req = vecs[v].req;
      @(posedge clk);
      #1;
      chk($sformatf("v%0d grant", v),    32'(grant),     32'(vecs[v].grant));
      chk($sformatf("v%0d mem_en", v),   32'(mem_en),    32'(vecs[v].mem_en));
      chk($sformatf("v%0d mem_addr", v), 32'(mem_addr),  32'(vecs[v].mem_addr));
      chk($sformatf("v%0d rvalid", v),   32'(rvalid),    32'(vecs[v].rvalid));
      chk($sformatf("v%0d rdata", v),    32'(rdata_out), 32'(vecs[v].rdata));
    end

`ifndef MEM_MUX_FIXED_PRIO_EN
    // Fairness: all channels requesting for 8 edges from a reset pointer -> two grants each, never the same channel twice in a row.
    rst = 1'b1;
    req = 4'b0000;
    @(posedge clk);
    #1;
    rst = 1'b0;
    req = 4'b1111;
    for (int c = 0; c < 4; c++) g_cnt[c] = 0;
    prev_g = 4'b0000;
    for (int n = 0; n < 8; n++) begin
      @(posedge clk);
      #1;
      for (int c = 0; c < 4; c++) if (grant[c]) g_cnt[c]++;
      chk($sformatf("fair step%0d repeat", n), 32'(grant == prev_g), 32'd0);
      prev_g = grant;
    end
    for (int c = 0; c < 4; c++) chk($sformatf("fair ch%0d count", c), 32'(g_cnt[c]), 32'd2);
`endif

    // Reset asserted while the previous grant's data is in flight drops it.
    rst = 1'b0;
    req = 4'b1000;
    @(posedge clk);
    #1;
    chk("midflight grant", 32'(grant), 32'(4'b1000));
    rst = 1'b1;
    req = 4'b0000;
    @(posedge clk);
    #1;
    chk("midflight rvalid", 32'(rvalid), 32'd0);
    chk("midflight rdata", 32'(rdata_out), 32'd0);
    rst = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
